multiword_cla_adder: RTL
========================

# multiword_cla_adder

Multi-cycle wide-operand adder that streams two W-bit operands, NUMBITS bits per cycle, through one instance of `carry_look_ahead_adder #(NUMBITS)`. The chunk carry-out is registered and fed back as the next chunk's carry-in. The block sits directly around the combinational CLA: it feeds it operand chunks and consumes its `result`/`carryout`. This trades NUMCHUNKS cycles of latency for a short critical path on very wide additions. Both sides use a valid/ready handshake.

## Interface
- NUMBITS, 4, chunk width; also the width of the internal `carry_look_ahead_adder`.
- NUMCHUNKS, 4, number of chunks per operation; must be ≥ 2.
- W (localparam), NUMBITS*NUMCHUNKS, total operand width.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  block can accept an operation.
- A  input  W  operand A; sampled only on accept.
- B  input  W  operand B; sampled only on accept.
- carryin  input  1  carry into chunk 0; sampled only on accept.
- out_valid  output  1  result and carryout are valid.
- out_ready  input  1  downstream accepts the result.
- result  output  W  sum modulo 2^W.
- carryout  output  1  carry out of the most-significant chunk.

## Operation
- FSM states: IDLE, RUN, DONE. Reset value is IDLE.
- Outputs in each state:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
  - in_ready and out_valid are decoded from state only, with no combinational path from inputs.
- Accept is `in_valid && in_ready` at an edge.
  - On accept, register A and B into operand registers and carryin into the carry register.
  - Clear the chunk index to 0 and go to RUN.
- RUN, once per cycle:
  - Drive the CLA with `A_reg[idx*NUMBITS +: NUMBITS]`, the matching B_reg chunk, and carry_reg.
  - At the edge, write the CLA result into `result[idx*NUMBITS +: NUMBITS]` and write the CLA carryout into carry_reg.
  - Increment idx.
  - When idx == NUMCHUNKS-1 at the edge, go to DONE instead.
- DONE: carryout = carry_reg. result and carryout are held stable until the handshake `out_valid && out_ready` completes, then go to IDLE.
- Arithmetic: {carryout, result} == A + B + carryin, computed as a full (W+1)-bit sum. There is no signed interpretation.
- result and carryout are defined only while out_valid=1. Between operations they hold their previous values, and they may update chunk-wise during RUN.
- Inputs are ignored outside IDLE:
  - in_valid while busy has no effect.
  - Changes to A, B or carryin after accept have no effect.
- Reset is synchronous and applies in any state, including mid-RUN. On the next edge:
  - state=IDLE, idx=0, carry_reg=0, result=0, carryout=0, operand registers=0.
  - No out_valid is produced for the aborted operation.

## Timing
- Accept at edge k: RUN is active during cycles k+1 .. k+NUMCHUNKS.
- out_valid rises after edge k+NUMCHUNKS; latency is NUMCHUNKS cycles from accept to out_valid.
- Output handshake at edge m: in_ready=1 after edge m. The earliest next accept is edge m+1.
- Throughput: one operation per NUMCHUNKS+2 cycles when out_ready is held high.
- No back-to-back overlap: DONE→IDLE and IDLE→RUN never happen on the same edge.
- Backpressure: out_ready low holds DONE indefinitely, with result and carryout unchanged.
- Reset wins over every handshake in the same cycle.
- Only one NUMBITS-bit CLA is on the combinational path per cycle.

## Test plan
- Reset check (NUMBITS=4, NUMCHUNKS=4): hold reset 2 cycles → in_ready=1, out_valid=0, result=16'h0000, carryout=0.
- Full carry ripple: accept A=16'hFFFF, B=16'h0001, carryin=0 → out_valid exactly 4 cycles after accept, result=16'h0000, carryout=1.
- Carry-in path: A=16'h00FF, B=16'h0001, carryin=1 → result=16'h0101, carryout=0.
  - Also A=16'hD5D5, B=16'h6464, carryin=0 → result=16'h3A39, carryout=1.
- Backpressure and busy:
  - Hold out_ready=0 for 3 cycles in DONE → out_valid stays 1 and result is stable.
  - in_ready stays 0; in_valid=1 with new operands is ignored.
  - After the out_ready handshake, the next operation is accepted one cycle later.
- Reset mid-operation: assert reset during RUN at idx=2 → next edge gives IDLE, in_ready=1, out_valid=0, result=0. A following op 16'h000C+16'h0002 yields 16'h000E, carryout=0.
- Wide config (NUMBITS=8, NUMCHUNKS=16): A=128'hFF…FF, B=128'h1, carryin=0 → out_valid after 16 cycles, result=0, carryout=1. Compare 200 random operand pairs against A+B+carryin.

Source files
------------

// File: rtl/multiword_cla_adder.sv
// Multi-cycle wide adder: streams NUMBITS-bit chunks of two W-bit operands
// through one carry-lookahead adder, feeding the chunk carry back each cycle.

module carry_look_ahead_adder #(
  parameter int NUMBITS = 4
) (
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  input  logic               carryin,
  output logic [NUMBITS-1:0] result,
  output logic               carryout
);

  logic [NUMBITS-1:0] gen;
  logic [NUMBITS-1:0] prop;
  logic [NUMBITS:0]   carry;
  logic               acc;
  logic               prop_run;

  // Each carry is the fully expanded lookahead sum of products, not a ripple.
  always_comb begin
    gen      = A & B;
    prop     = A ^ B;
    carry    = '0;
    acc      = 1'b0;
    prop_run = 1'b1;
    carry[0] = carryin;
    for (int i = 0; i < NUMBITS; i++) begin
      acc      = 1'b0;
      prop_run = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc      = acc | (prop_run & gen[j]);
        prop_run = prop_run & prop[j];
      end
      carry[i+1] = acc | (prop_run & carryin);
    end
    result   = prop ^ carry[NUMBITS-1:0];
    carryout = carry[NUMBITS];
  end

endmodule

module multiword_cla_adder #(
  parameter int NUMBITS   = 4,
  parameter int NUMCHUNKS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUMBITS*NUMCHUNKS-1:0]   A,
  input  logic [NUMBITS*NUMCHUNKS-1:0]   B,
  input  logic                           carryin,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUMBITS*NUMCHUNKS-1:0]   result,
  output logic                           carryout
);

  localparam int W    = NUMBITS * NUMCHUNKS;
  localparam int IDXW = (NUMCHUNKS > 1) ? $clog2(NUMCHUNKS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUMCHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                carry_q, carry_d;
  logic                carryout_q, carryout_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [W-1:0]        result_q, result_d;

  logic [NUMBITS-1:0]  cla_a;
  logic [NUMBITS-1:0]  cla_b;
  logic [NUMBITS-1:0]  cla_sum;
  logic                cla_cout;

  assign cla_a = a_q[idx_q*NUMBITS +: NUMBITS];
  assign cla_b = b_q[idx_q*NUMBITS +: NUMBITS];

  carry_look_ahead_adder #(
    .NUMBITS (NUMBITS)
  ) u_cla (
    .A        (cla_a),
    .B        (cla_b),
    .carryin  (carry_q),
    .result   (cla_sum),
    .carryout (cla_cout)
  );

  // Handshake outputs come from state alone so there is no input-to-output path.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    carryout_d = carryout_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = carryin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[idx_q*NUMBITS +: NUMBITS] = cla_sum;
        carry_d = cla_cout;
        if (idx_q == LAST_IDX) begin
          carryout_d = cla_cout;
          state_d    = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      carryout_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      carryout_q <= carryout_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
    end
  end

  assign result   = result_q;
  assign carryout = carryout_q;

endmodule
